// File: rtl/move_commit_pkg.sv
// Shared Go board types, colour constants and the move_commit FSM encoding.
package go_pkg;

  typedef logic [1:0] stone_t;

  localparam stone_t EMPTY = 2'b00;
  localparam stone_t BLACK = 2'b01;
  localparam stone_t WHITE = 2'b10;

  // Indexed board[row][col], each element one stone_t.
  typedef stone_t [8:0][8:0] board_t;

  localparam logic [3:0] BOARD_MAX = 4'd8;
  localparam logic [7:0] PASS_CODE = 8'hFF;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    CHECK  = 4'b0010,
    COMMIT = 4'b0100,
    REFUSE = 4'b1000
  } state_t;

  function automatic stone_t other_color(stone_t c);
    return (c == BLACK) ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/move_commit_if.sv
// Move request/response handshake between the front ends (local, remote link) and move_commit.
interface move_commit_if;
  logic       move_ready;
  logic [7:0] move_in;
  logic       pass_in;
  logic       remote_ready;
  logic [7:0] remote_move;
  logic       remote_pass;
  logic       move_ack;
  logic       move_reject;
  logic       resp_remote;

  modport master (
    output move_ready, move_in, pass_in, remote_ready, remote_move, remote_pass,
    input  move_ack, move_reject, resp_remote
  );

  modport slave (
    input  move_ready, move_in, pass_in, remote_ready, remote_move, remote_pass,
    output move_ack, move_reject, resp_remote
  );
endinterface

// File: rtl/move_commit.sv
// Validates and commits local/remote moves into the authoritative 9x9 board and turn state.
// Optional MOVE_HISTORY_EN builds the last_move / move_count registers.
module move_commit
  import go_pkg::*;
#(
  parameter stone_t LOCAL_COLOR = BLACK,
  parameter stone_t FIRST_COLOR = BLACK
) (
  input  logic         clk_in,
  input  logic         reset,
  move_commit_if.slave mv,
  output board_t       board,
  output logic         my_turn,
  output logic         game_over,
  output logic [7:0]   last_move,
  output logic [7:0]   move_count
);

  state_t     state;
  stone_t     turn;
  logic       req_remote;
  logic       req_pass;
  logic [3:0] req_row;
  logic [3:0] req_col;
  logic [1:0] pass_run;

  logic       local_on_turn;
  logic       take_remote;
  logic       in_range;
  stone_t     target;
  logic       reject_c;

  assign local_on_turn = (turn == LOCAL_COLOR);
  assign my_turn       = local_on_turn;

  // Simultaneous strobes: the side on turn wins; once the game is over local wins.
  always_comb begin
    take_remote = mv.remote_ready;
    if (mv.move_ready && mv.remote_ready)
      take_remote = !game_over && !local_on_turn;
  end

  assign in_range = (req_row <= BOARD_MAX) && (req_col <= BOARD_MAX);

  always_comb begin
    target = EMPTY;
    if (in_range) target = board[req_row][req_col];
  end

  // A requester is off turn when its remote-ness matches local being on turn.
  assign reject_c = game_over
                 || (req_remote == local_on_turn)
                 || (!req_pass && (!in_range || (target != EMPTY)));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state          <= IDLE;
      board          <= '0;
      turn           <= FIRST_COLOR;
      game_over      <= 1'b0;
      pass_run       <= 2'd0;
      req_remote     <= 1'b0;
      req_pass       <= 1'b0;
      req_row        <= 4'd0;
      req_col        <= 4'd0;
      mv.move_ack    <= 1'b0;
      mv.move_reject <= 1'b0;
      mv.resp_remote <= 1'b0;
    end else begin
      mv.move_ack    <= 1'b0;
      mv.move_reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mv.move_ready || mv.remote_ready) begin
            req_remote <= take_remote;
            req_pass   <= take_remote ? mv.remote_pass      : mv.pass_in;
            req_row    <= take_remote ? mv.remote_move[7:4] : mv.move_in[7:4];
            req_col    <= take_remote ? mv.remote_move[3:0] : mv.move_in[3:0];
            state      <= CHECK;
          end
        end
        CHECK: state <= reject_c ? REFUSE : COMMIT;
        COMMIT: begin
          if (req_pass) begin
            pass_run <= pass_run + 2'd1;
            if (pass_run == 2'd1) game_over <= 1'b1;
          end else begin
            board[req_row][req_col] <= turn;
            pass_run                <= 2'd0;
          end
          turn           <= other_color(turn);
          mv.move_ack    <= 1'b1;
          mv.resp_remote <= req_remote;
          state          <= IDLE;
        end
        REFUSE: begin
          mv.move_reject <= 1'b1;
          mv.resp_remote <= req_remote;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MOVE_HISTORY_EN
  always_ff @(posedge clk_in) begin
    if (reset) begin
      last_move  <= PASS_CODE;
      move_count <= 8'h00;
    end else if (state == COMMIT) begin
      last_move <= req_pass ? PASS_CODE : {req_row, req_col};
      if (move_count != 8'hFF) move_count <= move_count + 8'd1;
    end
  end
`else
  assign last_move  = PASS_CODE;
  assign move_count = 8'h00;
`endif

endmodule
